// File: rtl/ah_stream_pkg.sv
// rtl/ah_stream_pkg.sv - shared types and helpers for the stream mux/demux fabric
//
// Contents:
//   arb_state_t : arbitration state (ST_IDLE picks a source, ST_LOCK holds it)
//   sel_width() : source-index width, max(1, $clog2(n))

package ah_stream_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  // A single source still needs a 1-bit index so select ports never vanish.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ah_rr_arbiter.sv
// rtl/ah_rr_arbiter.sv - combinational circular priority pick
//
// Picks the first set request bit scanning circularly from ptr+1.
// Ports:
//   req  in  NUM_ING  request vector
//   ptr  in  SEL_W    last served index (lowest priority this round)
//   any  out 1        at least one request is set
//   idx  out SEL_W    winning index (0 when any=0)

module ah_rr_arbiter
  import ah_stream_pkg::*;
#(
  parameter int NUM_ING = 18,
  parameter int SEL_W   = sel_width(NUM_ING)
) (
  input  logic [NUM_ING-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic             up_hit;
  logic [SEL_W-1:0] up_idx;
  logic             lo_hit;
  logic [SEL_W-1:0] lo_idx;

  // Two candidates: the lowest request strictly above ptr, and the lowest
  // request overall. The first wins when present; otherwise the scan wraps.
  // Scanning downward lets later (lower) hits overwrite earlier ones.
  always_comb begin
    up_hit = 1'b0;
    up_idx = '0;
    lo_hit = 1'b0;
    lo_idx = '0;
    for (int i = NUM_ING - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_hit = 1'b1;
        lo_idx = SEL_W'(i);
        if (SEL_W'(i) > ptr) begin
          up_hit = 1'b1;
          up_idx = SEL_W'(i);
        end
      end
    end
  end

  assign any = lo_hit;
  assign idx = up_hit ? up_idx : lo_idx;

endmodule

// File: rtl/ah_rr_arb_mux.sv
// rtl/ah_rr_arb_mux.sv - round-robin packet-locked N-to-1 stream mux with registered egress
//
// Gathers packets from NUM_ING ingress streams onto one egress stream. Grant
// is held from arbitration until the granted port's last beat. Each egress
// beat carries the index of the ingress it came from.
// Ports:
//   clk         in  1               rising-edge clock
//   rst         in  1               synchronous active-high reset
//   ing_data    in  NUM_ING*DATA_W  flattened payloads, port i at [i*DATA_W +: DATA_W]
//   ing_valid   in  NUM_ING         per-port valid
//   ing_last    in  NUM_ING         per-port end-of-packet
//   ing_ready   out NUM_ING         per-port ready (only the granted port, only in LOCK)
//   egr_data    out DATA_W          registered payload
//   egr_select  out SEL_W           registered source index
//   egr_last    out 1               registered end-of-packet
//   egr_valid   out 1               registered valid
//   egr_ready   in  1               downstream ready

module ah_rr_arb_mux
  import ah_stream_pkg::*;
#(
  parameter int NUM_ING = 18,
  parameter int DATA_W  = 9,
  parameter int SEL_W   = sel_width(NUM_ING)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_ING*DATA_W-1:0]  ing_data,
  input  logic [NUM_ING-1:0]         ing_valid,
  input  logic [NUM_ING-1:0]         ing_last,
  output logic [NUM_ING-1:0]         ing_ready,
  output logic [DATA_W-1:0]          egr_data,
  output logic [SEL_W-1:0]           egr_select,
  output logic                       egr_last,
  output logic                       egr_valid,
  input  logic                       egr_ready
);

  arb_state_t       state;
  logic [SEL_W-1:0] gnt;
  logic [SEL_W-1:0] ptr;

  logic             arb_any;
  logic [SEL_W-1:0] arb_idx;

  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              gnt_ready;
  logic              xfer;

  ah_rr_arbiter #(
    .NUM_ING (NUM_ING),
    .SEL_W   (SEL_W)
  ) u_arb (
    .req (ing_valid),
    .ptr (ptr),
    .any (arb_any),
    .idx (arb_idx)
  );

  // Granted port's beat, selected by compare rather than by indexing with gnt
  // so the mux stays width-clean for any NUM_ING.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_ING; i++) begin
      if (gnt == SEL_W'(i)) begin
        sel_valid = ing_valid[i];
        sel_last  = ing_last[i];
        sel_data  = ing_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output register can take a beat when empty or being drained this cycle.
  // Depends only on state and egress handshake, never on ing_valid.
  assign gnt_ready = (state == ST_LOCK) & (~egr_valid | egr_ready);
  assign xfer      = gnt_ready & sel_valid;

  always_comb begin
    ing_ready = '0;
    for (int i = 0; i < NUM_ING; i++) begin
      ing_ready[i] = gnt_ready & (gnt == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      ptr        <= SEL_W'(NUM_ING - 1);
      egr_valid  <= 1'b0;
      egr_data   <= '0;
      egr_select <= '0;
      egr_last   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            gnt   <= arb_idx;
            state <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          // Grant is released only by the last beat; a granted port that
          // drops valid mid-packet simply stalls the mux.
          if (xfer && sel_last) begin
            ptr   <= gnt;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (xfer) begin
        egr_data   <= sel_data;
        egr_select <= gnt;
        egr_last   <= sel_last;
        egr_valid  <= 1'b1;
      end else if (egr_ready) begin
        egr_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ah_rr_arb_mux.sv
// tb/tb_ah_rr_arb_mux.sv - self-checking bench for ah_rr_arb_mux
module tb_ah_rr_arb_mux;

  localparam int N    = 18;
  localparam int DW   = 9;
  localparam int SW   = 5;
  localparam int MAXB = 64;

  logic clk;
  logic rst;

  logic [N*DW-1:0] ing_data;
  logic [N-1:0]    ing_valid;
  logic [N-1:0]    ing_last;
  logic [N-1:0]    ing_ready;
  logic [DW-1:0]   egr_data;
  logic [SW-1:0]   egr_select;
  logic            egr_last;
  logic            egr_valid;
  logic            egr_ready;

  logic [DW-1:0] u_data;
  logic [0:0]    u_valid;
  logic [0:0]    u_last;
  logic [0:0]    u_ready;
  logic [DW-1:0] u_egr_data;
  logic [0:0]    u_egr_select;
  logic          u_egr_last;
  logic          u_egr_valid;
  logic          u_egr_ready;

  ah_rr_arb_mux #(.NUM_ING(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .ing_data(ing_data), .ing_valid(ing_valid), .ing_last(ing_last), .ing_ready(ing_ready),
    .egr_data(egr_data), .egr_select(egr_select), .egr_last(egr_last),
    .egr_valid(egr_valid), .egr_ready(egr_ready)
  );

  ah_rr_arb_mux #(.NUM_ING(1), .DATA_W(DW)) dut1 (
    .clk(clk), .rst(rst),
    .ing_data(u_data), .ing_valid(u_valid), .ing_last(u_last), .ing_ready(u_ready),
    .egr_data(u_egr_data), .egr_select(u_egr_select), .egr_last(u_egr_last),
    .egr_valid(u_egr_valid), .egr_ready(u_egr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- sources and reference model ----------------
  typedef struct {
    logic [DW-1:0] data;
    int            sel;
    logic          last;
  } beat_t;

  logic [DW-1:0] sd [N][MAXB];
  logic          sl [N][MAXB];
  int            slen [N];
  int            shead [N];
  beat_t         exp_in[$];
  beat_t         exp_out[$];

  task automatic drv_clear();
    ing_valid = '0;
    ing_last  = '0;
    ing_data  = '0;
  endtask

  task automatic set_port(input int p, input logic [DW-1:0] d, input logic l);
    ing_valid[p]         = 1'b1;
    ing_data[p*DW +: DW] = d;
    ing_last[p]          = l;
  endtask

  task automatic clear_src();
    for (int p = 0; p < N; p++) begin
      slen[p]  = 0;
      shead[p] = 0;
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    for (int k = 0; k < len; k++) begin
      sd[p][slen[p]] = DW'($urandom);
      sl[p][slen[p]] = (k == len - 1);
      slen[p]++;
    end
  endtask

  // Packet-level round robin: after serving port q, the next packet comes
  // from the first port after q (circularly) that still has packets queued.
  task automatic build_expected();
    int pos [N];
    int cur;
    int q;
    bit found;
    bit done;
    beat_t b;
    exp_in.delete();
    exp_out.delete();
    for (int p = 0; p < N; p++) pos[p] = 0;
    cur  = N - 1;
    done = 0;
    while (!done) begin
      found = 0;
      q = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && pos[(cur + k) % N] < slen[(cur + k) % N]) begin
          found = 1;
          q = (cur + k) % N;
        end
      end
      if (!found) begin
        done = 1;
      end else begin
        do begin
          b.data = sd[q][pos[q]];
          b.sel  = q;
          b.last = sl[q][pos[q]];
          pos[q]++;
          exp_in.push_back(b);
          exp_out.push_back(b);
        end while (!b.last);
        cur = q;
      end
    end
  endtask

  task automatic do_reset();
    drv_clear();
    u_valid = '0; u_last = '0; u_data = '0; u_egr_ready = 1'b0;
    egr_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_engine(input int gap_pct, input int stall_pct, input bit check_timing,
                            input int fs_start, input int fs_len, input int budget);
    bit mid [N];
    bit prev_stall;
    logic [DW-1:0] prev_d;
    logic [SW-1:0] prev_s;
    logic prev_l;
    int last_cyc;
    bit last_was_last;
    int cyc;
    beat_t b;
    for (int p = 0; p < N; p++) mid[p] = 0;
    prev_stall = 0; prev_d = '0; prev_s = '0; prev_l = 1'b0;
    last_cyc = -1; last_was_last = 1; cyc = 0;
    while (exp_out.size() > 0 && cyc < budget) begin
      egr_ready = ($urandom_range(99) >= stall_pct) && !(cyc >= fs_start && cyc < fs_start + fs_len);
      drv_clear();
      for (int p = 0; p < N; p++) begin
        if (shead[p] < slen[p] && !(mid[p] && $urandom_range(99) < gap_pct))
          set_port(p, sd[p][shead[p]], sl[p][shead[p]]);
      end
      @(negedge clk);
      if (prev_stall) begin
        chk("hold_valid", egr_valid, 1);
        chk("hold_data", egr_data, prev_d);
        chk("hold_select", egr_select, prev_s);
        chk("hold_last", egr_last, prev_l);
      end
      if (egr_valid && !egr_ready) chk("stall_ready", ing_ready, 0);
      if (exp_in.size() > 0) begin
        if (ing_ready != '0) chk("ready_port", ing_ready, longint'(1) << exp_in[0].sel);
      end else begin
        chk("ready_idle", ing_ready, 0);
      end
      for (int p = 0; p < N; p++) begin
        if (ing_valid[p] && ing_ready[p]) begin
          if (exp_in.size() == 0) begin
            chk("extra_ingress", p, -1);
          end else begin
            b = exp_in.pop_front();
            chk("in_port", p, b.sel);
          end
          shead[p]++;
          mid[p] = !ing_last[p];
        end
      end
      if (egr_valid && egr_ready) begin
        if (exp_out.size() == 0) begin
          chk("extra_egress", 1, 0);
        end else begin
          b = exp_out.pop_front();
          chk("egr_data", egr_data, b.data);
          chk("egr_select", egr_select, b.sel);
          chk("egr_last", egr_last, b.last);
          if (check_timing) begin
            if (last_cyc < 0) chk("first_latency", cyc, 2);
            else chk("beat_gap", cyc - last_cyc, last_was_last ? 2 : 1);
          end
          last_cyc = cyc;
          last_was_last = b.last;
        end
      end
      prev_stall = egr_valid && !egr_ready;
      prev_d = egr_data; prev_s = egr_select; prev_l = egr_last;
      tick();
      cyc++;
    end
    chk("drain", exp_out.size(), 0);
    drv_clear();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    int            port;
    logic [DW-1:0] d;
    logic          l;
    logic          rdy;
    logic          ev;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    logic          el;
    logic [N-1:0]  ir;
  } vec_t;

  function automatic vec_t mk(input int port, input logic [DW-1:0] d, input logic l, input logic rdy,
                              input logic ev, input logic [DW-1:0] ed, input logic [SW-1:0] es,
                              input logic el, input logic [N-1:0] ir);
    vec_t v;
    v.port = port; v.d = d; v.l = l; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.es = es; v.el = el; v.ir = ir;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drv_clear();
    egr_ready = 1'b0;
    u_valid = '0; u_last = '0; u_data = '0; u_egr_ready = 1'b0;

    // Port 3 single beat, then a backpressured 2-beat packet from port 7.
    tbl.push_back(mk( 3, 9'h1A5, 1, 1,  0, 9'h000, 0, 0, 18'h0));
    tbl.push_back(mk( 3, 9'h1A5, 1, 1,  0, 9'h000, 0, 0, 18'h1 << 3));
    tbl.push_back(mk(-1, 9'h000, 0, 1,  1, 9'h1A5, 3, 1, 18'h0));
    tbl.push_back(mk(-1, 9'h000, 0, 1,  0, 9'h1A5, 3, 1, 18'h0));
    tbl.push_back(mk( 7, 9'h011, 0, 0,  0, 9'h1A5, 3, 1, 18'h0));
    tbl.push_back(mk( 7, 9'h011, 0, 0,  0, 9'h1A5, 3, 1, 18'h1 << 7));
    tbl.push_back(mk( 7, 9'h022, 1, 0,  1, 9'h011, 7, 0, 18'h0));
    tbl.push_back(mk( 7, 9'h022, 1, 0,  1, 9'h011, 7, 0, 18'h0));
    tbl.push_back(mk( 7, 9'h022, 1, 1,  1, 9'h011, 7, 0, 18'h1 << 7));
    tbl.push_back(mk(-1, 9'h000, 0, 0,  1, 9'h022, 7, 1, 18'h0));
    tbl.push_back(mk(-1, 9'h000, 0, 1,  1, 9'h022, 7, 1, 18'h0));
    tbl.push_back(mk(-1, 9'h000, 0, 1,  0, 9'h022, 7, 1, 18'h0));

    do_reset();
    for (int r = 0; r < tbl.size(); r++) begin
      drv_clear();
      if (tbl[r].port >= 0) set_port(tbl[r].port, tbl[r].d, tbl[r].l);
      egr_ready = tbl[r].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", r), egr_valid, tbl[r].ev);
      chk($sformatf("tbl%0d_data", r), egr_data, tbl[r].ed);
      chk($sformatf("tbl%0d_select", r), egr_select, tbl[r].es);
      chk($sformatf("tbl%0d_last", r), egr_last, tbl[r].el);
      chk($sformatf("tbl%0d_ready", r), ing_ready, tbl[r].ir);
      tick();
    end

    // Ports 0, 5, 17 continuously with 2-beat packets: order and bubbles.
    do_reset();
    clear_src();
    for (int k = 0; k < 2; k++) begin
      add_pkt(0, 2); add_pkt(5, 2); add_pkt(17, 2);
    end
    build_expected();
    run_engine(0, 0, 1, 0, 0, 200);

    // Granted port 5 drops valid for 3 cycles while port 2 requests.
    do_reset();
    egr_ready = 1'b1;
    set_port(5, 9'h050, 0);
    @(negedge clk); chk("gap_c0_ready", ing_ready, 0); tick();
    set_port(2, 9'h020, 1);
    @(negedge clk); chk("gap_c1_ready", ing_ready, 18'h1 << 5); tick();
    ing_valid[5] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("gap_hold%0d_ready", c), ing_ready, 18'h1 << 5);
      if (c == 0) chk("gap_first_data", egr_data, 9'h050);
      tick();
    end
    set_port(5, 9'h051, 1);
    @(negedge clk); chk("gap_resume_ready", ing_ready, 18'h1 << 5); tick();
    ing_valid[5] = 1'b0;
    @(negedge clk);
    chk("gap_idle_ready", ing_ready, 0);
    chk("gap_last_data", egr_data, 9'h051);
    chk("gap_last_sel", egr_select, 5);
    tick();
    @(negedge clk); chk("gap_p2_ready", ing_ready, 18'h1 << 2); tick();
    drv_clear();
    @(negedge clk);
    chk("gap_p2_data", egr_data, 9'h020);
    chk("gap_p2_sel", egr_select, 2);
    chk("gap_p2_valid", egr_valid, 1);
    tick();

    // egr_ready held low for 4 cycles with a beat in the output register.
    do_reset();
    clear_src();
    add_pkt(9, 3);
    build_expected();
    run_engine(0, 0, 0, 3, 4, 200);

    // Reset in the cycle after the first beat of a 4-beat packet from port 7.
    do_reset();
    egr_ready = 1'b1;
    set_port(7, 9'h070, 0);
    @(negedge clk); tick();
    @(negedge clk); chk("rst_p7_ready", ing_ready, 18'h1 << 7); tick();
    set_port(7, 9'h071, 0);
    rst = 1'b1;
    @(negedge clk); chk("rst_pre_data", egr_data, 9'h070); tick();
    rst = 1'b0;
    drv_clear();
    set_port(0, 9'h100, 1);
    set_port(7, 9'h072, 0);
    @(negedge clk);
    chk("rst_valid", egr_valid, 0);
    chk("rst_data", egr_data, 0);
    chk("rst_select", egr_select, 0);
    chk("rst_last", egr_last, 0);
    chk("rst_ready", ing_ready, 0);
    tick();
    @(negedge clk); chk("rst_rearb_ready", ing_ready, 18'h1); tick();
    drv_clear();
    @(negedge clk);
    chk("rst_p0_valid", egr_valid, 1);
    chk("rst_p0_sel", egr_select, 0);
    chk("rst_p0_data", egr_data, 9'h100);
    tick();

    // Randomized traffic against the packet-level model.
    for (int round = 0; round < 3; round++) begin
      do_reset();
      clear_src();
      for (int p = 0; p < N; p++) begin
        int npk;
        npk = $urandom_range(0, 2);
        for (int k = 0; k < npk; k++) add_pkt(p, $urandom_range(1, 4));
      end
      add_pkt($urandom_range(0, N - 1), 2);
      build_expected();
      run_engine(round * 20, round * 25, 0, 0, 0, 4000);
    end

    // NUM_ING=1: back-to-back 3-beat packets.
    do_reset();
    begin
      int sent;
      int got;
      int exp_cyc [6];
      exp_cyc[0] = 2; exp_cyc[1] = 3; exp_cyc[2] = 4;
      exp_cyc[3] = 6; exp_cyc[4] = 7; exp_cyc[5] = 8;
      sent = 0;
      got = 0;
      u_egr_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
        u_valid[0] = (sent < 6);
        u_data     = DW'(9'h040 + sent);
        u_last[0]  = (sent % 3 == 2);
        @(negedge clk);
        if (u_valid[0] && u_ready[0]) sent++;
        if (u_egr_valid) begin
          if (got < 6) begin
            chk("n1_data", u_egr_data, 9'h040 + got);
            chk("n1_sel", u_egr_select, 0);
            chk("n1_last", u_egr_last, (got % 3 == 2));
            chk("n1_cycle", c, exp_cyc[got]);
          end else begin
            chk("n1_extra", got, 5);
          end
          got++;
        end
        tick();
      end
      chk("n1_count", got, 6);
      u_valid = '0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
